// File: rtl/act_pingpong_ram_pkg.sv
// Shared accelerator definitions for the ping-pong activation RAM:
// the operating-mode encoding and the default geometry constants.
package act_pingpong_ram_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_LOAD    = 2'd1,
        MODE_COMPUTE = 2'd2,
        MODE_DRAIN   = 2'd3
    } act_ram_mode_e;

    localparam int ACT_NUM_K    = 4;
    localparam int ACT_DEPTH    = 64;
    localparam int ACT_DATA_W   = 16;
    localparam int ACT_IDX_W    = 4;
    localparam int ACT_WR_LANES = 4;
    localparam int ACT_RD_LANES = 4;

endpackage

// File: rtl/act_pingpong_ram_lane_compactor.sv
// Prefix-sum lane compactor: gives each accepted lane its slot offset
// among the accepted lanes (ascending lane order) plus the total accepted.
module lane_compactor #(
    parameter int LANES = 4,
    parameter int OFF_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]       accept,
    output logic [LANES*OFF_W-1:0] offset,
    output logic [OFF_W-1:0]       total
);

    logic [OFF_W-1:0] run;

    // NOTE: blocking assignments are correct here; 'run' is a running sum
    // that each loop iteration must see updated, and it is defaulted first.
    always_comb begin
        run    = '0;
        offset = '0;
        for (int i = 0; i < LANES; i++) begin
            offset[i*OFF_W +: OFF_W] = run;
            run = run + OFF_W'(accept[i]);
        end
        total = run;
    end

endmodule

// File: rtl/act_pingpong_ram.sv
// Ping-pong activation RAM: two banks of per-channel compressed {data, idx}
// entries. Optional macro ACT_RAM_ZERO_SKIP_EN drops zero-valued lanes on write.
module act_pingpong_ram
    import act_pingpong_ram_pkg::*;
#(
    parameter int NUM_K    = ACT_NUM_K,
    parameter int DEPTH    = ACT_DEPTH,
    parameter int DATA_W   = ACT_DATA_W,
    parameter int IDX_W    = ACT_IDX_W,
    parameter int WR_LANES = ACT_WR_LANES,
    parameter int RD_LANES = ACT_RD_LANES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         layer_parity,
    input  logic [$clog2(NUM_K)-1:0]     cur_k,
    input  logic [WR_LANES-1:0]          in_valid,
    input  logic [WR_LANES*DATA_W-1:0]   in_data,
    input  logic [WR_LANES*IDX_W-1:0]    in_idx,
    input  logic                         rd_req,
    input  logic [$clog2(DEPTH)-1:0]     rd_base,
    output logic [RD_LANES*DATA_W-1:0]   rd_data,
    output logic [RD_LANES*IDX_W-1:0]    rd_idx,
    output logic [RD_LANES-1:0]          rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
    output logic                         overflow
);

    localparam int A_W = $clog2(DEPTH);
    localparam int C_W = $clog2(DEPTH + 1);
    localparam int S_W = C_W + 1;
    localparam int O_W = $clog2(WR_LANES + 1);
    localparam logic [S_W-1:0] DEPTH_S = S_W'(DEPTH);

    act_ram_mode_e mode_e, mode_q;
    logic          par_q;
    logic [C_W-1:0] cnt [2][NUM_K];
    logic [DATA_W-1:0] mem_data [2][NUM_K][DEPTH];
    logic [IDX_W-1:0]  mem_idx  [2][NUM_K][DEPTH];

    logic                 wr_active, wr_bank, entering;
    logic [WR_LANES-1:0]  accept;
    logic [WR_LANES*O_W-1:0] offset;
    logic [O_W-1:0]       total;
    logic [C_W-1:0]       wr_base, next_cnt;
    logic [S_W-1:0]       wr_end;
    logic [S_W-1:0]       wr_addr [WR_LANES];
    logic [S_W-1:0]       rd_addr [RD_LANES];
    logic [RD_LANES-1:0]  rd_hit, rd_in_range;

    assign mode_e    = act_ram_mode_e'(mode);
    assign entering  = (mode_e != mode_q);
    assign wr_active = (mode_e == MODE_LOAD) || (mode_e == MODE_DRAIN);
    assign wr_bank   = (mode_e == MODE_LOAD) ? par_q : ~par_q;
    // The first write of a LOAD/DRAIN phase lands at 0 even though the clear is still in flight.
    assign wr_base   = entering ? '0 : cnt[wr_bank][cur_k];
    assign wr_end    = S_W'(wr_base) + S_W'(total);
    assign next_cnt  = (wr_end > DEPTH_S) ? C_W'(DEPTH) : wr_end[C_W-1:0];
    assign fill_cnt  = cnt[par_q][cur_k];

    always_comb begin
        for (int i = 0; i < WR_LANES; i++) begin
`ifdef ACT_RAM_ZERO_SKIP_EN
            accept[i] = wr_active && in_valid[i] && (|in_data[i*DATA_W +: DATA_W]);
`else
            accept[i] = wr_active && in_valid[i];
`endif
            wr_addr[i] = S_W'(wr_base) + S_W'(offset[i*O_W +: O_W]);
        end
    end

    lane_compactor #(
        .LANES (WR_LANES),
        .OFF_W (O_W)
    ) u_compactor (
        .accept (accept),
        .offset (offset),
        .total  (total)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_IDLE;
            par_q    <= 1'b0;
            overflow <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < NUM_K; k++)
                    cnt[b][k] <= '0;
        end else begin
            mode_q <= mode_e;
            if (mode_e == MODE_IDLE)
                par_q <= layer_parity;
            for (int k = 0; k < NUM_K; k++) begin
                if (entering && mode_e == MODE_LOAD)  cnt[par_q][k]  <= '0;
                if (entering && mode_e == MODE_DRAIN) cnt[~par_q][k] <= '0;
            end
            if (|accept) begin
                cnt[wr_bank][cur_k] <= next_cnt;
                if (wr_end > DEPTH_S)
                    overflow <= 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; entries beyond each count are never reported valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_LANES; i++) begin
            if (accept[i] && wr_addr[i] < DEPTH_S) begin
                mem_data[wr_bank][cur_k][wr_addr[i][A_W-1:0]] <= in_data[i*DATA_W +: DATA_W];
                mem_idx[wr_bank][cur_k][wr_addr[i][A_W-1:0]]  <= in_idx[i*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RD_LANES; i++) begin
            rd_addr[i]     = S_W'(rd_base) + S_W'(i);
            rd_in_range[i] = rd_addr[i] < DEPTH_S;
            rd_hit[i]      = rd_addr[i] < S_W'(cnt[par_q][cur_k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= '0;
            rd_data  <= '0;
            rd_idx   <= '0;
        end else if (mode_e == MODE_COMPUTE && rd_req) begin
            for (int i = 0; i < RD_LANES; i++) begin
                rd_valid[i] <= rd_hit[i];
                if (rd_in_range[i]) begin
                    rd_data[i*DATA_W +: DATA_W] <= mem_data[par_q][cur_k][rd_addr[i][A_W-1:0]];
                    rd_idx[i*IDX_W +: IDX_W]    <= mem_idx[par_q][cur_k][rd_addr[i][A_W-1:0]];
                end
            end
        end else begin
            rd_valid <= '0;
        end
    end

endmodule

// File: tb/tb_act_pingpong_ram.sv
// Self-checking bench for act_pingpong_ram: a behavioural bank model feeds a
// read scoreboard; honours ACT_RAM_ZERO_SKIP_EN when the build defines it.
module tb_act_pingpong_ram;
    import act_pingpong_ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        layer_parity;
    logic [1:0]  cur_k;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [15:0] in_idx;
    logic        rd_req;
    logic [5:0]  rd_base;
    logic [63:0] rd_data;
    logic [15:0] rd_idx;
    logic [3:0]  rd_valid;
    logic [6:0]  fill_cnt;
    logic        overflow;

    act_pingpong_ram dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .layer_parity (layer_parity),
        .cur_k        (cur_k),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_idx       (in_idx),
        .rd_req       (rd_req),
        .rd_base      (rd_base),
        .rd_data      (rd_data),
        .rd_idx       (rd_idx),
        .rd_valid     (rd_valid),
        .fill_cnt     (fill_cnt),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [15:0] idx;
        logic [3:0]  valid;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    int mdl_mem [2][4][64];
    int mdl_cnt [2][4];
    int mdl_par;
    bit mdl_ovf;
    logic [1:0] mdl_prev;
    logic [63:0] last_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] idx_of(input int d);
        return 4'((d * 7 + 3) & 15);
    endfunction

    function automatic bit accepted(input int d);
`ifdef ACT_RAM_ZERO_SKIP_EN
        return d != 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 4; k++) mdl_cnt[b][k] = 0;
        mdl_par  = 0;
        mdl_ovf  = 0;
        mdl_prev = MODE_IDLE;
    endtask

    // Drives one cycle, predicts its effect, then checks the registered read.
    task automatic step(input logic [1:0] m, input int k, input logic [3:0] v,
                        input int d0, input int d1, input int d2, input int d3,
                        input logic par, input logic req, input int base, input string tag);
        int d[4];
        rd_exp_t e;
        int b, pos;
        logic [63:0] mask;
        logic [15:0] imask;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        mode = m; cur_k = 2'(k); in_valid = v; layer_parity = par;
        rd_req = req; rd_base = 6'(base);
        for (int i = 0; i < 4; i++) begin
            in_data[i*16 +: 16] = 16'(d[i]);
            in_idx[i*4 +: 4]    = idx_of(d[i]);
        end
        e.data = '0; e.idx = '0; e.valid = '0;
        if (m == MODE_COMPUTE && req) begin
            for (int i = 0; i < 4; i++) begin
                if (base + i < mdl_cnt[mdl_par][k]) begin
                    e.valid[i]         = 1'b1;
                    e.data[i*16 +: 16] = 16'(mdl_mem[mdl_par][k][base+i]);
                    e.idx[i*4 +: 4]    = idx_of(mdl_mem[mdl_par][k][base+i]);
                end
            end
        end
        rd_q.push_back(e);

        if (m != mdl_prev && m == MODE_LOAD)
            for (int kk = 0; kk < 4; kk++) mdl_cnt[mdl_par][kk] = 0;
        if (m != mdl_prev && m == MODE_DRAIN)
            for (int kk = 0; kk < 4; kk++) mdl_cnt[1-mdl_par][kk] = 0;
        if (m == MODE_LOAD || m == MODE_DRAIN) begin
            b   = (m == MODE_LOAD) ? mdl_par : 1 - mdl_par;
            pos = mdl_cnt[b][k];
            for (int i = 0; i < 4; i++) begin
                if (v[i] && accepted(d[i])) begin
                    if (pos < 64) mdl_mem[b][k][pos] = d[i];
                    pos++;
                end
            end
            if (pos > 64) begin
                mdl_ovf = 1'b1;
                pos = 64;
            end
            mdl_cnt[b][k] = pos;
        end
        if (m == MODE_IDLE) mdl_par = int'(par);
        mdl_prev = m;

        @(posedge clk);
        #1;
        e = rd_q.pop_front();
        mask = '0; imask = '0;
        for (int i = 0; i < 4; i++) if (e.valid[i]) begin
            mask[i*16 +: 16] = 16'hffff;
            imask[i*4 +: 4]  = 4'hf;
        end
        check({tag, "_vld"}, 64'(rd_valid), 64'(e.valid));
        if (e.valid != 4'b0) begin
            check({tag, "_dat"}, rd_data & mask, e.data & mask);
            check({tag, "_idx"}, 64'(rd_idx & imask), 64'(e.idx & imask));
            last_data = rd_data & mask;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_fill"}, 64'(fill_cnt), 64'(mdl_cnt[mdl_par][cur_k]));
        check({tag, "_ovf"},  64'(overflow), 64'(mdl_ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mode = MODE_IDLE; layer_parity = 1'b0; cur_k = '0;
        in_valid = '0; in_data = '0; in_idx = '0; rd_req = 1'b0; rd_base = '0;
        last_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 64'(rd_valid), 64'd0);
        check("rst_dat", rd_data, 64'd0);
        check_state("rst");
        rst = 1'b0;

        // Basic compaction into bank0, then windowed reads
        step(MODE_IDLE, 0, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 0, "idle0");
        step(MODE_LOAD, 1, 4'b1011, 5, 6, 7, 8, 1'b0, 1'b0, 0, "ld1");
        check("ld1_fill_abs", 64'(fill_cnt), 64'd3);
        step(MODE_COMPUTE, 1, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 1, "rd_b1");
        check("rd_b1_abs", 64'(rd_valid), 64'b0011);
        step(MODE_COMPUTE, 1, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 0, "rd_b0");
        step(MODE_COMPUTE, 1, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 0, "rd_off");
        check("rd_hold", rd_data & 64'h0000_ffff_ffff_ffff, last_data);

        // Parity change outside IDLE is ignored; in_valid in COMPUTE ignored
        step(MODE_COMPUTE, 1, 4'b1111, 1, 2, 3, 4, 1'b1, 1'b1, 0, "par_cmp");
        check_state("par_cmp");
        step(MODE_IDLE, 1, 4'b1111, 1, 2, 3, 4, 1'b1, 1'b0, 0, "idle1");
        check_state("idle1");
        step(MODE_LOAD, 1, 4'b1111, 9, 10, 11, 12, 1'b0, 1'b0, 0, "ld_b1");
        check_state("ld_b1");
        step(MODE_COMPUTE, 1, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 0, "rd_bank1");

        // DRAIN writes the output bank and clears its counts on entry
        step(MODE_DRAIN, 2, 4'b0011, 20, 21, 0, 0, 1'b0, 1'b0, 0, "drain");
        step(MODE_IDLE, 2, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 0, "idle2");
        step(MODE_COMPUTE, 2, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 0, "rd_drain");
        step(MODE_COMPUTE, 1, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 0, "rd_k1");
        check_state("drain_clr");

        // Zero-valued lanes: stored by default, skipped with the macro
        step(MODE_LOAD, 0, 4'b1111, 0, 3, 0, 4, 1'b0, 1'b0, 0, "ld_zero");
        check_state("ld_zero");
        step(MODE_COMPUTE, 0, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 0, "rd_zero");

        // Fill channel 3 to 62, then overflow it
        step(MODE_IDLE, 3, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 0, "idle3");
        for (int j = 0; j < 15; j++)
            step(MODE_LOAD, 3, 4'b1111, 100+4*j, 101+4*j, 102+4*j, 103+4*j, 1'b0, 1'b0, 0, "fill");
        step(MODE_LOAD, 3, 4'b0011, 180, 181, 0, 0, 1'b0, 1'b0, 0, "fill62");
        check_state("fill62");
        step(MODE_LOAD, 3, 4'b1111, 200, 201, 202, 203, 1'b0, 1'b0, 0, "ovf");
        check_state("ovf");
        check("ovf_abs", 64'(overflow), 64'd1);
        step(MODE_COMPUTE, 3, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 60, "rd_top");
        step(MODE_COMPUTE, 3, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 62, "rd_edge");
        step(MODE_COMPUTE, 3, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 63, "rd_last");
        step(MODE_IDLE, 3, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 0, "ovf_hold");
        check_state("ovf_hold");

        // Asynchronous reset mid-LOAD, then restart at address 0
        step(MODE_LOAD, 3, 4'b0111, 50, 51, 52, 0, 1'b0, 1'b0, 0, "ld_pre");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_vld", 64'(rd_valid), 64'd0);
        check_state("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(MODE_LOAD, 3, 4'b0001, 77, 0, 0, 0, 1'b0, 1'b0, 0, "ld_post");
        check_state("ld_post");
        step(MODE_COMPUTE, 3, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 0, "rd_post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/act_pingpong_ram.md
ACT_PINGPONG_RAM -- requirements
Module: act_pingpong_ram

Interface
REQ-001 SHALL have parameter NUM_K, default 4, number of output-channel lanes per bank.
REQ-002 SHALL have parameter DEPTH, default 64, compressed entries per channel per bank.
REQ-003 SHALL have parameter DATA_W, default 16, activation width.
REQ-004 SHALL have parameter IDX_W, default 4, zero-run index width.
REQ-005 SHALL have parameter WR_LANES, default 4, write lanes per cycle.
REQ-006 SHALL have parameter RD_LANES, default 4, read window width (the I multiplier count).
REQ-007 SHALL have one clock and an asynchronous, active-high reset: clk in 1 rising-edge clock; rst in 1 async active-high reset.
REQ-008 SHALL have ports: mode in 2 (0 IDLE, 1 LOAD, 2 COMPUTE, 3 DRAIN); layer_parity in 1 input-bank select; cur_k in clog2(NUM_K) channel; in_valid in WR_LANES; in_data in WR_LANES*DATA_W; in_idx in WR_LANES*IDX_W (DRAM in LOAD, PPU in DRAIN).
REQ-009 SHALL have ports: rd_req in 1; rd_base in clog2(DEPTH) window start; rd_data out RD_LANES*DATA_W; rd_idx out RD_LANES*IDX_W; rd_valid out RD_LANES; fill_cnt out clog2(DEPTH+1); overflow out 1 sticky.

Function
REQ-010 SHALL hold two banks, each NUM_K x DEPTH entries of {data, idx}, plus a count per bank per channel.
REQ-011 SHALL register layer_parity into par_q only while mode==IDLE; input bank = par_q, output bank = !par_q; parity changes in other modes ignored.
REQ-012 SHALL, on a transition into LOAD, clear all input-bank counts; on a transition into DRAIN, clear all output-bank counts; a write in that same cycle lands at address 0.
REQ-013 SHALL, in LOAD, compact valid lanes in ascending lane order into input bank [cur_k] starting at its count and add popcount(accepted lanes) to the count.
REQ-014 SHALL, in DRAIN, do the same into output bank [cur_k].
REQ-015 SHALL drop writes to addresses >= DEPTH, saturate the count at DEPTH, and set overflow, which is held until rst.
REQ-016 SHALL ignore in_valid in IDLE and COMPUTE.
REQ-017 SHALL, in COMPUTE with rd_req=1, register rd_data/rd_idx lane i = input bank [cur_k][rd_base+i] and rd_valid[i] = (rd_base+i < count), one-cycle latency.
REQ-018 SHALL drive rd_valid to 0 in the cycle after rd_req=0 or mode!=COMPUTE; rd_data holds its last value.
REQ-019 SHALL treat rd_base+i >= DEPTH as invalid with no address wrap.
REQ-020 SHALL drive fill_cnt combinationally as the input-bank count of cur_k.

Reset
REQ-021 SHALL, on rst, asynchronously clear counts, par_q, overflow, rd_valid, rd_data and rd_idx to 0.
REQ-022 SHALL not reset storage arrays; stale entries are masked by the counts.
REQ-023 SHALL, after rst is asserted mid-LOAD and then released, start at address 0.

Configuration
REQ-024 SHALL, with ACT_RAM_ZERO_SKIP_EN defined, treat valid lanes with in_data==0 as not accepted (no write, no count); without the macro, zero values are stored and counted.

Structure
REQ-025 SHALL define the mode enum (act_ram_mode_e) and default parameter constants in the shared accelerator package.
REQ-026 SHALL implement the prefix-sum lane compaction as a sub-module lane_compactor, shared by the LOAD and DRAIN paths.

Verification
REQ-027 SHALL verify: par_q=0, LOAD with k=1, in_valid=4'b1011, data 5,6,7,8 -> bank0[1][0..2]=5,6,8; fill_cnt=3.
REQ-028 SHALL verify: COMPUTE, rd_base=1, count 3 -> next cycle rd_data lanes 0/1 = 6,8; rd_valid=4'b0011.
REQ-029 SHALL verify: DEPTH=64, count 62, 4 valid lanes -> 2 entries written, count 64, overflow=1, held until rst.
REQ-030 SHALL verify: layer_parity toggled in COMPUTE -> bank unchanged; toggled in IDLE -> subsequent LOAD writes bank1.
REQ-031 SHALL verify: ACT_RAM_ZERO_SKIP_EN defined, data 0,3,0,4 all valid -> entries 3,4, count 2; undefined -> count 4.
REQ-032 SHALL verify: rst asserted mid-LOAD without a clock edge -> rd_valid, fill_cnt, overflow read 0 immediately.
